// File: rtl/fix_pkg.sv
// Shared constants and types for the fixed-layer sprite path.
// Holds no logic, so it adds no latency and applies no backpressure.
package fix_pkg;
  localparam int COORD_W = 10;
  localparam int IDX_W = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'h0;

  typedef enum logic {IDLE, FLASH} blink_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;
endpackage

// File: rtl/fix_pos_shadow.sv
// Double-buffered sprite position: pending slot filled by valid/ready, committed to active on frame_start.
// Accepted offer lands in pending next cycle; ready stays low while pending is full.
module fix_pos_shadow
  import fix_pkg::*;
#(
  parameter int INIT_X = 304,
  parameter int INIT_Y = 400
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_frame_start,
  input  logic i_pos_valid,
  input  pos_t i_pos,
  output logic o_pos_ready,
  output pos_t o_act
);
  pos_t r_act;
  pos_t r_pend;
  logic r_pend_full;
  logic w_accept;

  assign w_accept = i_pos_valid && !r_pend_full;

  // An offer taken in a frame_start cycle finds pending empty, so it waits a full frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_act       <= '{x: COORD_W'(INIT_X), y: COORD_W'(INIT_Y)};
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (i_frame_start && r_pend_full) begin
      r_act       <= r_pend;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend      <= i_pos;
      r_pend_full <= 1'b1;
    end
  end

  assign o_pos_ready = !r_pend_full;
  assign o_act       = r_act;
endmodule

// File: rtl/fix_sprite_fetch.sv
// Sprite fetch: hit test + ROM address, then palette index/opaque with hit-blink masking.
// Fixed 3-cycle latency from draw coordinates to pixel outputs; never stalls.
module fix_sprite_fetch
  import fix_pkg::*;
#(
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int INIT_X       = 304,
  parameter int INIT_Y       = 400,
  parameter int FLASH_FRAMES = 32,
  parameter int BLINK_DIV    = 4,
  localparam int ADDR_W      = $clog2(SPR_W*SPR_H)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_start,
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic               i_de,
  input  logic               i_pos_valid,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  output logic               o_pos_ready,
  input  logic               i_hit,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [IDX_W-1:0]   i_rom_data,
  output logic [IDX_W-1:0]   o_pix_index,
  output logic               o_pix_opaque,
  output logic               o_blinking
);
  localparam int CNT_W     = $clog2(FLASH_FRAMES);
  localparam int BLINK_BIT = $clog2(BLINK_DIV);

  pos_t                w_pos_in;
  pos_t                w_act;
  logic [COORD_W:0]    w_x_end;
  logic [COORD_W:0]    w_y_end;
  logic [COORD_W-1:0]  w_dx;
  logic [COORD_W-1:0]  w_dy;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_hit1;
  logic                w_blank;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_hit1;
  logic                r_hit2;
  logic [IDX_W-1:0]    r_pix_index;
  logic                r_pix_opaque;
  blink_state_t        r_state;
  blink_state_t        w_state_nxt;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [CNT_W-1:0]    w_frame_cnt_nxt;

  assign w_pos_in = '{x: i_pos_x, y: i_pos_y};

  fix_pos_shadow #(
    .INIT_X(INIT_X),
    .INIT_Y(INIT_Y)
  ) u_pos_shadow (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_frame_start(i_frame_start),
    .i_pos_valid  (i_pos_valid),
    .i_pos        (w_pos_in),
    .o_pos_ready  (o_pos_ready),
    .o_act        (w_act)
  );

  // One extra bit on the far edges so a sprite hanging past 1023 cannot wrap to the left.
  assign w_x_end = {1'b0, w_act.x} + (COORD_W+1)'(SPR_W);
  assign w_y_end = {1'b0, w_act.y} + (COORD_W+1)'(SPR_H);
  assign w_hit1  = i_de
                && (i_draw_x >= w_act.x) && ({1'b0, i_draw_x} < w_x_end)
                && (i_draw_y >= w_act.y) && ({1'b0, i_draw_y} < w_y_end);
  assign w_dx    = i_draw_x - w_act.x;
  assign w_dy    = i_draw_y - w_act.y;
  assign w_addr  = ADDR_W'(32'(w_dy) * SPR_W + 32'(w_dx));

  assign w_blank = (r_state == FLASH) && r_frame_cnt[BLINK_BIT];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rom_addr   <= '0;
      r_hit1       <= 1'b0;
      r_hit2       <= 1'b0;
      r_pix_index  <= TRANSPARENT_IDX;
      r_pix_opaque <= 1'b0;
    end else begin
      r_rom_addr   <= w_hit1 ? w_addr : '0;
      r_hit1       <= w_hit1;
      r_hit2       <= r_hit1;
      r_pix_index  <= r_hit2 ? i_rom_data : TRANSPARENT_IDX;
      r_pix_opaque <= r_hit2 && (i_rom_data != TRANSPARENT_IDX) && !w_blank;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // A hit always restarts the count, even when it lands on a frame_start.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (i_hit) begin
          w_state_nxt     = FLASH;
          w_frame_cnt_nxt = '0;
        end
      end
      FLASH: begin
        if (i_hit) begin
          w_frame_cnt_nxt = '0;
        end else if (i_frame_start) begin
          if (r_frame_cnt == CNT_W'(FLASH_FRAMES-1)) begin
            w_state_nxt     = IDLE;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_pix_index  = r_pix_index;
  assign o_pix_opaque = r_pix_opaque;
  assign o_blinking   = (r_state == FLASH);
endmodule
